// File: rtl/tdt_dm_sba_pkg.sv
// rtl/tdt_dm_sba_pkg.sv - shared constants, state encodings and helpers for the SBA controller
package tdt_dm_sba_pkg;

  localparam logic [6:0] ADDR_SBCS       = 7'h38;
  localparam logic [6:0] ADDR_SBADDRESS0 = 7'h39;
  localparam logic [6:0] ADDR_SBADDRESS1 = 7'h3a;
  localparam logic [6:0] ADDR_SBDATA0    = 7'h3c;
  localparam logic [6:0] ADDR_SBDATA1    = 7'h3d;

  localparam logic [2:0] SBERR_NONE    = 3'd0;
  localparam logic [2:0] SBERR_TIMEOUT = 3'd1;
  localparam logic [2:0] SBERR_BADADDR = 3'd2;
  localparam logic [2:0] SBERR_ALIGN   = 3'd3;
  localparam logic [2:0] SBERR_SIZE    = 3'd4;

  localparam logic [2:0] SBVERSION = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } sba_state_e;

  function automatic logic access_ok(input logic [2:0] acc, input logic dw64);
    return (acc == 3'd2) || (dw64 && (acc == 3'd3));
  endfunction

  // Only meaningful once access_ok has passed (size is 2 or 3).
  function automatic logic addr_aligned(input logic [2:0] lsbs, input logic [2:0] acc);
    return (acc == 3'd3) ? (lsbs == 3'd0) : (lsbs[1:0] == 2'd0);
  endfunction

endpackage

// File: rtl/tdt_sba_ctrl_fsm.sv
// rtl/tdt_sba_ctrl_fsm.sv - IDLE/REQ/WAIT sequencer with completion timeout
module tdt_sba_ctrl_fsm
  import tdt_dm_sba_pkg::*;
#(
  parameter int TIMEOUT_W = 12
) (
  input  logic g_mclk,
  input  logic mreset_b,
  input  logic start,
  input  logic axi_wr_ready,
  output logic busy,
  output logic wr_vld,
  output logic done,
  output logic timeout
);

  sba_state_e           state;
  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge g_mclk or negedge mreset_b) begin
    if (!mreset_b) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      wr_vld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_REQ;
            wr_vld <= 1'b1;
          end
        end
        ST_REQ: begin
          state  <= ST_WAIT;
          wr_vld <= 1'b0;
          cnt    <= '0;
        end
        ST_WAIT: begin
          if (axi_wr_ready || (cnt == '1)) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + TIMEOUT_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          wr_vld <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_WAIT) && axi_wr_ready;
  assign timeout = (state == ST_WAIT) && !axi_wr_ready && (cnt == '1);

endmodule

// File: rtl/tdt_sba_ctrl.sv
// rtl/tdt_sba_ctrl.sv - debug-module system bus access register file and command issue
module tdt_sba_ctrl
  import tdt_dm_sba_pkg::*;
#(
  parameter int SBA_DW         = 64,
  parameter int AXI_ADDR_WIDTH = 40,
  parameter int TIMEOUT_W      = 12
) (
  input  logic                      g_mclk,
  input  logic                      mreset_b,
  input  logic                      reg_wr_vld,
  input  logic                      reg_rd_vld,
  input  logic [6:0]                reg_addr,
  input  logic [31:0]               reg_wdata,
  output logic [31:0]               reg_rdata,
  output logic [SBA_DW-1:0]         wr_data,
  output logic                      wr_flg,
  output logic [AXI_ADDR_WIDTH-1:0] wr_addr,
  output logic                      wr_vld,
  output logic [2:0]                wr_size,
  input  logic [SBA_DW-1:0]         rd_data,
  input  logic                      axi_wr_ready,
  input  logic                      sba_error
);

  localparam int   AW   = AXI_ADDR_WIDTH;
  localparam int   HIW  = AW - 32;
  localparam logic DW64 = (SBA_DW == 64);

  logic          sbbusyerror;
  logic          sbreadonaddr;
  logic [2:0]    sbaccess;
  logic          sbautoincrement;
  logic          sbreadondata;
  logic [2:0]    sberror;
  logic [AW-1:0] addr;
  logic [31:0]   sbdata0;
  logic [31:0]   sbdata1;

  logic busy, done, timeout, start;

  logic w_sbcs, w_addr0, w_addr1, w_data0, w_data1, r_data0, r_data1;
  assign w_sbcs  = reg_wr_vld && (reg_addr == ADDR_SBCS);
  assign w_addr0 = reg_wr_vld && (reg_addr == ADDR_SBADDRESS0);
  assign w_addr1 = reg_wr_vld && (reg_addr == ADDR_SBADDRESS1);
  assign w_data0 = reg_wr_vld && (reg_addr == ADDR_SBDATA0);
  assign w_data1 = reg_wr_vld && (reg_addr == ADDR_SBDATA1);
  assign r_data0 = reg_rd_vld && (reg_addr == ADDR_SBDATA0);
  assign r_data1 = reg_rd_vld && (reg_addr == ADDR_SBDATA1);

  logic busy_hit;
  assign busy_hit = busy && (w_addr0 || w_addr1 || w_data0 || w_data1 || r_data0 || r_data1);

  logic can_trig, trig_wr, trig;
  assign can_trig = !busy && !sbbusyerror && (sberror == SBERR_NONE);
  assign trig_wr  = can_trig && w_data0;
  assign trig     = trig_wr || (can_trig && ((w_addr0 && sbreadonaddr) || (r_data0 && sbreadondata)));

  // The command must see the value being written this cycle, not the stale register.
  logic [AW-1:0] cmd_addr;
  logic [63:0]   cmd_data;
  logic [2:0]    pre_err;
  always_comb begin
    cmd_addr = addr;
    if (w_addr0) cmd_addr[31:0] = reg_wdata;
    cmd_data = {sbdata1, sbdata0};
    if (w_data0) cmd_data[31:0] = reg_wdata;
    pre_err = SBERR_NONE;
    if (!access_ok(sbaccess, DW64)) pre_err = SBERR_SIZE;
    else if (!addr_aligned(cmd_addr[2:0], sbaccess)) pre_err = SBERR_ALIGN;
  end

  assign start = trig && (pre_err == SBERR_NONE);

  logic [63:0]   rd64;
  logic [31:0]   addr_hi;
  logic [AW-1:0] inc;
  always_comb begin
    rd64               = '0;
    rd64[SBA_DW-1:0]   = rd_data;
    addr_hi            = '0;
    addr_hi[HIW-1:0]   = addr[AW-1:32];
  end
  assign inc = AW'(1) << sbaccess;

  tdt_sba_ctrl_fsm #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_fsm (
    .g_mclk      (g_mclk),
    .mreset_b    (mreset_b),
    .start       (start),
    .axi_wr_ready(axi_wr_ready),
    .busy        (busy),
    .wr_vld      (wr_vld),
    .done        (done),
    .timeout     (timeout)
  );

  // Later assignments win: completion errors override a same-cycle W1C of sberror.
  always_ff @(posedge g_mclk or negedge mreset_b) begin
    if (!mreset_b) begin
      sbbusyerror     <= 1'b0;
      sbreadonaddr    <= 1'b0;
      sbaccess        <= 3'd0;
      sbautoincrement <= 1'b0;
      sbreadondata    <= 1'b0;
      sberror         <= SBERR_NONE;
      addr            <= '0;
      sbdata0         <= '0;
      sbdata1         <= '0;
      wr_data         <= '0;
      wr_flg          <= 1'b0;
      wr_addr         <= '0;
      wr_size         <= 3'd0;
    end else begin
      if (w_sbcs) begin
        sbreadonaddr    <= reg_wdata[20];
        sbaccess        <= reg_wdata[19:17];
        sbautoincrement <= reg_wdata[16];
        sbreadondata    <= reg_wdata[15];
        sbbusyerror     <= sbbusyerror & ~reg_wdata[22];
        sberror         <= sberror & ~reg_wdata[14:12];
      end
      if (busy_hit) begin
        sbbusyerror <= 1'b1;
      end else begin
        if (w_addr0) addr[31:0]    <= reg_wdata;
        if (w_addr1) addr[AW-1:32] <= reg_wdata[HIW-1:0];
        if (w_data0) sbdata0       <= reg_wdata;
        if (w_data1) sbdata1       <= reg_wdata;
      end
      if (trig && (pre_err != SBERR_NONE)) sberror <= pre_err;
      if (start) begin
        wr_flg  <= trig_wr;
        wr_addr <= cmd_addr;
        wr_data <= cmd_data[SBA_DW-1:0];
        wr_size <= sbaccess;
      end
      if (timeout) sberror <= SBERR_TIMEOUT;
      if (done) begin
        if (!wr_flg) begin
          sbdata0 <= rd64[31:0];
          if (wr_size == 3'd3) sbdata1 <= rd64[63:32];
        end
        if (sba_error) sberror <= SBERR_BADADDR;
        else if (sbautoincrement) addr <= addr + inc;
      end
    end
  end

  logic [31:0] rdata_mux;
  always_comb begin
    rdata_mux = '0;
    case (reg_addr)
      ADDR_SBCS: rdata_mux = {SBVERSION, 6'd0, sbbusyerror, busy, sbreadonaddr, sbaccess,
                              sbautoincrement, sbreadondata, sberror, 7'(AXI_ADDR_WIDTH),
                              1'b0, DW64, 1'b1, 2'b00};
      ADDR_SBADDRESS0: rdata_mux = addr[31:0];
      ADDR_SBADDRESS1: rdata_mux = addr_hi;
      ADDR_SBDATA0:    rdata_mux = sbdata0;
      ADDR_SBDATA1:    rdata_mux = sbdata1;
      default:         rdata_mux = '0;
    endcase
  end

  always_ff @(posedge g_mclk or negedge mreset_b) begin
    if (!mreset_b) reg_rdata <= '0;
    else if (reg_rd_vld) reg_rdata <= rdata_mux;
  end

endmodule

// File: tb/tb_tdt_sba_ctrl.sv
// tb/tb_tdt_sba_ctrl.sv - directed self-checking bench for tdt_sba_ctrl
module tb_tdt_sba_ctrl;

  logic        g_mclk = 1'b0;
  logic        mreset_b;
  logic        reg_wr_vld, reg_rd_vld;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [63:0] wr_data;
  logic        wr_flg, wr_vld;
  logic [39:0] wr_addr;
  logic [2:0]  wr_size;
  logic [63:0] rd_data;
  logic        axi_wr_ready, sba_error;

  int vectors = 0;
  int miscompares = 0;
  int vld_cnt = 0;
  int snap;

  always #5 g_mclk = ~g_mclk;
  always @(posedge g_mclk) if (wr_vld) vld_cnt++;

  tdt_sba_ctrl dut (
    .g_mclk(g_mclk), .mreset_b(mreset_b),
    .reg_wr_vld(reg_wr_vld), .reg_rd_vld(reg_rd_vld), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .wr_data(wr_data), .wr_flg(wr_flg), .wr_addr(wr_addr), .wr_vld(wr_vld), .wr_size(wr_size),
    .rd_data(rd_data), .axi_wr_ready(axi_wr_ready), .sba_error(sba_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
    @(negedge g_mclk);
    reg_wr_vld = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge g_mclk);
    reg_wr_vld = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
    @(negedge g_mclk);
    reg_rd_vld = 1'b1; reg_addr = a;
    @(negedge g_mclk);
    reg_rd_vld = 1'b0;
    chk(tag, 64'(reg_rdata), 64'(exp));
  endtask

  task automatic wait_cmd(input string tag);
    int n = 0;
    while (!wr_vld && n < 20) begin
      @(negedge g_mclk);
      n++;
    end
    chk(tag, 64'(wr_vld), 64'd1);
  endtask

  task automatic respond(input logic [63:0] d, input logic e, input int dly);
    repeat (dly) @(negedge g_mclk);
    axi_wr_ready = 1'b1; rd_data = d; sba_error = e;
    @(negedge g_mclk);
    axi_wr_ready = 1'b0; rd_data = '0; sba_error = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mreset_b = 1'b0; reg_wr_vld = 1'b0; reg_rd_vld = 1'b0; reg_addr = '0; reg_wdata = '0;
    rd_data = '0; axi_wr_ready = 1'b0; sba_error = 1'b0;
    repeat (3) @(negedge g_mclk);
    chk("rst_wr_vld", 64'(wr_vld), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_reg_rdata", 64'(reg_rdata), 64'd0);
    mreset_b = 1'b1;
    rd_chk("rst_sbcs", 7'h38, 32'h2000_050C);

    // Read on address, size 3
    dmi_wr(7'h38, 32'h0016_0000);
    snap = vld_cnt;
    dmi_wr(7'h39, 32'h0000_1000);
    wait_cmd("rd_cmd");
    chk("rd_flg", 64'(wr_flg), 64'd0);
    chk("rd_addr", 64'(wr_addr), 64'h1000);
    chk("rd_size", 64'(wr_size), 64'd3);
    respond(64'h1122_3344_5566_7788, 1'b0, 5);
    chk("rd_pulses", 64'(vld_cnt - snap), 64'd1);
    rd_chk("rd_sbdata1", 7'h3d, 32'h1122_3344);
    rd_chk("rd_sbdata0", 7'h3c, 32'h5566_7788);
    rd_chk("rd_sbcs_idle", 7'h38, 32'h2016_050C);

    // Size 2 writes with autoincrement
    dmi_wr(7'h38, 32'h0005_0000);
    dmi_wr(7'h39, 32'h0000_2000);
    snap = vld_cnt;
    for (int i = 0; i < 3; i++) begin
      dmi_wr(7'h3c, 32'hDEAD_BEEF);
      wait_cmd("ai_cmd");
      chk("ai_flg", 64'(wr_flg), 64'd1);
      chk("ai_addr", 64'(wr_addr), 64'h2000 + 64'(4 * i));
      chk("ai_data", wr_data, 64'h1122_3344_DEAD_BEEF);
      respond(64'd0, 1'b0, 2);
    end
    chk("ai_pulses", 64'(vld_cnt - snap), 64'd3);
    rd_chk("ai_sbaddress0", 7'h39, 32'h0000_200C);

    // Alignment and size pre-checks
    dmi_wr(7'h38, 32'h0014_0000);
    snap = vld_cnt;
    dmi_wr(7'h39, 32'h0000_1002);
    repeat (4) @(negedge g_mclk);
    chk("align_no_vld", 64'(vld_cnt - snap), 64'd0);
    rd_chk("align_sbcs", 7'h38, 32'h2014_350C);
    dmi_wr(7'h38, 32'h0014_7000);
    rd_chk("align_clr", 7'h38, 32'h2014_050C);
    dmi_wr(7'h38, 32'h0018_0000);
    dmi_wr(7'h39, 32'h0000_1000);
    repeat (4) @(negedge g_mclk);
    chk("size_no_vld", 64'(vld_cnt - snap), 64'd0);
    rd_chk("size_sbcs", 7'h38, 32'h2018_450C);
    dmi_wr(7'h38, 32'h0018_7000);

    // Completion timeout, late ready ignored
    dmi_wr(7'h38, 32'h0016_0000);
    dmi_wr(7'h39, 32'h0000_3000);
    wait_cmd("to_cmd");
    repeat (3990) @(negedge g_mclk);
    rd_chk("to_busy", 7'h38, 32'h2036_050C);
    repeat (200) @(negedge g_mclk);
    rd_chk("to_sbcs", 7'h38, 32'h2016_150C);
    respond(64'hAAAA_AAAA_BBBB_BBBB, 1'b0, 1);
    rd_chk("to_sbdata0", 7'h3c, 32'hDEAD_BEEF);
    rd_chk("to_sbdata1", 7'h3d, 32'h1122_3344);
    dmi_wr(7'h38, 32'h0016_7000);

    // Busy violation
    dmi_wr(7'h39, 32'h0000_4000);
    wait_cmd("be_cmd");
    dmi_wr(7'h3c, 32'h1234_5678);
    respond(64'h0102_0304_0506_0708, 1'b0, 2);
    rd_chk("be_sbdata0", 7'h3c, 32'h0506_0708);
    rd_chk("be_sbdata1", 7'h3d, 32'h0102_0304);
    rd_chk("be_sbcs", 7'h38, 32'h2056_050C);
    snap = vld_cnt;
    dmi_wr(7'h39, 32'h0000_5000);
    repeat (4) @(negedge g_mclk);
    chk("be_blocked", 64'(vld_cnt - snap), 64'd0);
    dmi_wr(7'h38, 32'h0056_0000);
    rd_chk("be_clr", 7'h38, 32'h2016_050C);
    dmi_wr(7'h39, 32'h0000_5000);
    wait_cmd("be_retry_cmd");
    chk("be_retry_addr", 64'(wr_addr), 64'h5000);
    respond(64'h0102_0304_0506_0708, 1'b0, 2);

    // Bus error: no autoincrement
    dmi_wr(7'h38, 32'h0005_0000);
    dmi_wr(7'h39, 32'h0000_6000);
    dmi_wr(7'h3c, 32'hCAFE_F00D);
    wait_cmd("err_cmd");
    respond(64'd0, 1'b1, 3);
    rd_chk("err_sbcs", 7'h38, 32'h2005_250C);
    rd_chk("err_sbaddress0", 7'h39, 32'h0000_6000);

    // Read on data
    dmi_wr(7'h38, 32'h0004_F000);
    dmi_wr(7'h39, 32'h0000_7000);
    rd_chk("rod_rdata", 7'h3c, 32'hCAFE_F00D);
    wait_cmd("rod_cmd");
    chk("rod_flg", 64'(wr_flg), 64'd0);
    chk("rod_addr", 64'(wr_addr), 64'h7000);
    chk("rod_size", 64'(wr_size), 64'd2);
    respond(64'hFFFF_FFFF_8765_4321, 1'b0, 1);
    rd_chk("rod_sbdata1", 7'h3d, 32'h0102_0304);
    dmi_wr(7'h38, 32'h0004_0000);
    rd_chk("rod_sbdata0", 7'h3c, 32'h8765_4321);

    // Reset during WAIT
    dmi_wr(7'h38, 32'h0016_0000);
    dmi_wr(7'h39, 32'h0000_8000);
    wait_cmd("rst_cmd");
    @(negedge g_mclk);
    mreset_b = 1'b0;
    #1;
    chk("mrst_wr_vld", 64'(wr_vld), 64'd0);
    chk("mrst_wr_addr", 64'(wr_addr), 64'd0);
    chk("mrst_wr_data", wr_data, 64'd0);
    chk("mrst_wr_flg", 64'(wr_flg), 64'd0);
    chk("mrst_wr_size", 64'(wr_size), 64'd0);
    chk("mrst_reg_rdata", 64'(reg_rdata), 64'd0);
    @(negedge g_mclk);
    mreset_b = 1'b1;
    respond(64'h5555_5555_6666_6666, 1'b0, 1);
    rd_chk("mrst_sbcs", 7'h38, 32'h2000_050C);
    rd_chk("mrst_sbdata0", 7'h3c, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdt_sba_ctrl.md
Name: tdt_sba_ctrl

Overview:
- Debug-module System Bus Access controller per RISC-V Debug Spec 0.13: owns the sbcs, sbaddress0/1 and sbdata0/1 registers.
- Converts DMI register accesses into single-beat commands for the downstream AXI SBA master (wr_* command interface), then captures its completion (axi_wr_ready, rd_data, sba_error).
- Handles autoincrement, readonaddr/readondata triggering, busy/error tracking and a completion timeout.

Parameters:
- SBA_DW, 64, system-bus data width; 32 or 64 only.
- AXI_ADDR_WIDTH, 40, bus address width, 33..64; bits above 31 are held in sbaddress1.
- TIMEOUT_W, 12, timeout counter width; timeout fires at all-ones.

Ports:
- g_mclk  in  1  clock
- mreset_b  in  1  async active-low reset
- reg_wr_vld  in  1  DMI register write strobe, one cycle
- reg_rd_vld  in  1  DMI register read strobe, one cycle
- reg_addr  in  7  DMI address: 0x38 sbcs, 0x39 sbaddress0, 0x3a sbaddress1, 0x3c sbdata0, 0x3d sbdata1
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, registered, valid the cycle after reg_rd_vld
- wr_data  out  SBA_DW  command write data, {sbdata1,sbdata0}
- wr_flg  out  1  1 = write, 0 = read
- wr_addr  out  AXI_ADDR_WIDTH  command address
- wr_vld  out  1  one-cycle command pulse
- wr_size  out  3  sbaccess value
- rd_data  in  SBA_DW  read result, LSB-aligned, valid with axi_wr_ready
- axi_wr_ready  in  1  completion pulse
- sba_error  in  1  bus error for the completed access, valid with axi_wr_ready

Behaviour:
- Reset:
  - All registers 0; FSM in IDLE; wr_vld = 0; reg_rdata = 0.
  - wr_data, wr_flg, wr_addr and wr_size are 0.
- sbcs read layout:
  - [31:29] = 3'd1 (sbversion); [22] sbbusyerror; [21] sbbusy; [20] sbreadonaddr; [19:17] sbaccess; [16] sbautoincrement; [15] sbreadondata; [14:12] sberror.
  - [11:5] = AXI_ADDR_WIDTH; [3] = (SBA_DW==64); [2] = 1; [1:0] = 0.
- sbcs write:
  - Fields [20], [19:17], [16] and [15] are written directly.
  - sbbusyerror and sberror are write-1-to-clear, bitwise.
- FSM states: IDLE -> REQ -> WAIT -> IDLE.
  - sbbusy = (state != IDLE).
  - REQ drives wr_vld = 1 for exactly one cycle. wr_* are registered and stable from REQ until the return to IDLE.
  - WAIT increments the timeout counter each cycle.
  - On axi_wr_ready in WAIT, return to IDLE. For a read, sbdata0 <= rd_data[31:0], and for size 3, sbdata1 <= rd_data[63:32]. If sba_error, sberror <= 3'd2.
  - If the counter reaches all-ones before axi_wr_ready, sberror <= 3'd1 and the FSM returns to IDLE. An axi_wr_ready arriving in IDLE is ignored.
- Triggers, evaluated only when IDLE and sbbusyerror == 0 and sberror == 0:
  - Write to sbaddress0 with sbreadonaddr = 1 starts a read.
  - Write to sbdata0 starts a write.
  - Read of sbdata0 with sbreadondata = 1: reg_rdata returns the current value, then a read starts.
  - The trigger moves IDLE -> REQ on the next cycle.
- Pre-checks at trigger time, with no bus access issued on failure:
  - sbaccess not in {2, 3 if SBA_DW==64} -> sberror = 4.
  - Address misaligned for the size (addr[1:0] != 0 for size 2, addr[2:0] != 0 for size 3) -> sberror = 3.
- Busy violations:
  - Any write to sbaddress0/1 or sbdata0/1, or any read of sbdata0/1, while sbbusy = 1 sets sbbusyerror = 1.
  - That register write is dropped and no trigger fires.
- Autoincrement: on successful completion (no error) with sbautoincrement = 1, {sbaddress1,sbaddress0} += (1 << sbaccess), truncated to AXI_ADDR_WIDTH and wrapping at the top.
- Simultaneous events:
  - A DMI write to sbcs in the completion cycle: the W1C applies before error capture. A new error is set even if that same cycle's write clears the old one.
- Reset mid-operation: the FSM returns to IDLE immediately and any in-flight completion is lost.

Decomposition:
- Shared package tdt_dm_sba_pkg: DMI address constants for the five registers, sberror codes (TIMEOUT=1, BADADDR=2, ALIGN=3, SIZE=4), FSM state encodings, and sbversion.
- Sub-module tdt_sba_ctrl_fsm (IDLE/REQ/WAIT plus the timeout counter). The register file stays in the top level.

Test Plan:
- sbcs = 0x0010_0000|(3<<17) (readonaddr, size 3); write sbaddress0 = 0x1000; respond rd_data = 0x1122334455667788 after 5 cycles -> one wr_vld pulse with wr_flg = 0, wr_addr = 0x1000, wr_size = 3; sbdata1 = 0x11223344, sbdata0 = 0x55667788; sbbusy low after completion.
- Size 2 with autoincrement: write sbdata0 = 0xDEADBEEF three times, addr 0x2000 -> wr_addr sequence 0x2000/0x2004/0x2008; sbaddress0 = 0x200C.
- Write sbaddress0 = 0x1002 with size 2 and readonaddr -> no wr_vld; sberror = 3; write sbcs with [14:12] = 3'b111 -> sberror = 0.
- Start a read, hold axi_wr_ready low for 4095+ cycles -> sberror = 1, FSM IDLE; a late axi_wr_ready leaves sbdata unchanged.
- While busy, write sbdata0 -> sbbusyerror = 1 and the original access completes. The next trigger is blocked until W1C of bit 22.
- Completion with sba_error = 1 -> sberror = 2 and no autoincrement. Assert mreset_b low in WAIT -> all outputs 0 and the FSM in IDLE.
